// File: rtl/dlx_pkg.sv
// Shared DLX fetch-side definitions: sequencer state encoding, reset vector, widths.
// Latency: none (types, constants and a pure combinational helper only).
// Backpressure: not applicable.
package dlx_pkg;

  localparam int INSTR_W        = 32;
  localparam int OFFSET_SHORT_W = 16;
  localparam int OFFSET_LONG_W  = 26;

  localparam logic [INSTR_W-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } seqState_t;

  // Sign-extend the raw offset field: 26-bit form for j/jal, 16-bit form for branches.
  function automatic logic [INSTR_W-1:0] sextOffset(input logic [OFFSET_LONG_W-1:0] imm,
                                                    input logic longOffset);
    if (longOffset)
      return {{(INSTR_W-OFFSET_LONG_W){imm[OFFSET_LONG_W-1]}}, imm};
    return {{(INSTR_W-OFFSET_SHORT_W){imm[OFFSET_SHORT_W-1]}}, imm[OFFSET_SHORT_W-1:0]};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch/ID control bundle between the datapath (master) and the PC sequencer (slave).
// Latency: wires only.
// Backpressure: stall and imem_ready carry all flow control; no other handshake.
interface pc_sequencer_if;
  import dlx_pkg::*;

  logic                     stall;
  logic                     leap;
  logic                     reg_jump;
  logic                     long_offset;
  logic                     link;
  logic [INSTR_W-1:0]       busA;
  logic [OFFSET_LONG_W-1:0] imm;
  logic                     imem_ready;
  logic [INSTR_W-1:0]       fetch_pc;
  logic                     fetch_valid;
  logic [INSTR_W-1:0]       id_pc;
  logic                     id_valid;
  logic                     link_we;
  logic [INSTR_W-1:0]       link_value;

  modport master (
    output stall, leap, reg_jump, long_offset, link, busA, imm, imem_ready,
    input  fetch_pc, fetch_valid, id_pc, id_valid, link_we, link_value
  );

  modport slave (
    input  stall, leap, reg_jump, long_offset, link, busA, imm, imem_ready,
    output fetch_pc, fetch_valid, id_pc, id_valid, link_we, link_value
  );

endinterface

// File: rtl/pc_target.sv
// Branch/jump target adder: id_pc + 4 + sext(offset), or busA for register jumps, word aligned.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever its inputs are.
module pc_target
  import dlx_pkg::*;
(
  input  logic [INSTR_W-1:0]       idPc,
  input  logic [INSTR_W-1:0]       busA,
  input  logic [OFFSET_LONG_W-1:0] imm,
  input  logic                     longOffset,
  input  logic                     regJump,
  output logic [INSTR_W-1:0]       target
);

  logic [INSTR_W-1:0] relTarget;
  logic [INSTR_W-1:0] rawTarget;

  // Relative target wraps modulo 2^32 by construction of the fixed-width add.
  assign relTarget = idPc + 32'd4 + sextOffset(imm, longOffset);
  assign rawTarget = regJump ? busA : relTarget;
  assign target    = rawTarget & ~32'h0000_0003;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: owns PC and IF/ID pc/valid, redirects on leap, squashes wrong path, makes link value.
// Latency: redirect target on fetch_pc one edge after leap; link_we/link_value combinational.
// Backpressure: stall freezes everything; imem_ready=0 holds PC (WAIT). Option macro: PC_SEQ_DELAY_SLOT_EN.
module pc_sequencer
  import dlx_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  seqState_t          state;
  seqState_t          stateNext;
  logic               fetchValid;
  logic [INSTR_W-1:0] pcReg;
  logic [INSTR_W-1:0] idPcReg;
  logic               idValidReg;
  logic [INSTR_W-1:0] target;
  logic               redirect;
  logic               squash;
  logic [INSTR_W-1:0] linkValue;

  pc_target uTarget (
    .idPc      (idPcReg),
    .busA      (bus.busA),
    .imm       (bus.imm),
    .longOffset(bus.long_offset),
    .regJump   (bus.reg_jump),
    .target    (target)
  );

  // A stalled leap is ignored; upstream keeps it asserted until the stall clears.
  assign redirect = bus.leap & idValidReg & ~bus.stall;

`ifdef PC_SEQ_DELAY_SLOT_EN
  // The instruction fetched alongside the redirect is the delay slot and must execute.
  assign squash    = 1'b0;
  assign linkValue = idPcReg + 32'd8;
`else
  assign squash    = redirect;
  assign linkValue = idPcReg + 32'd4;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= stateNext;
  end

  // Next-state logic and fetch request; a redirect always lands in RUN to fetch the target.
  always_comb begin
    stateNext  = state;
    fetchValid = 1'b0;
    case (state)
      BOOT: begin
        if (!bus.stall) stateNext = RUN;
      end
      RUN: begin
        fetchValid = 1'b1;
        if (!bus.stall && !bus.imem_ready && !redirect) stateNext = WAIT;
      end
      WAIT: begin
        fetchValid = 1'b1;
        if (!bus.stall && (bus.imem_ready || redirect)) stateNext = RUN;
      end
      default: stateNext = BOOT;
    endcase
  end

  // PC register: redirect beats sequential advance; an unreturned fetch is simply re-aimed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcReg <= RESET_VECTOR;
    end else if (!bus.stall && state != BOOT) begin
      if (redirect)            pcReg <= target;
      else if (bus.imem_ready) pcReg <= pcReg + 32'd4;
    end
  end

  // IF/ID register: captures the fetch address, valid only for returned, non-squashed fetches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idPcReg    <= '0;
      idValidReg <= 1'b0;
    end else if (!bus.stall) begin
      idPcReg    <= pcReg;
      idValidReg <= bus.imem_ready & fetchValid & ~squash;
    end
  end

  assign bus.fetch_pc    = pcReg;
  assign bus.fetch_valid = fetchValid;
  assign bus.id_pc       = idPcReg;
  assign bus.id_valid    = idValidReg;
  assign bus.link_we     = bus.link & redirect;
  assign bus.link_value  = linkValue;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized run against a model.
// Latency: inputs change 1 time unit after the rising edge; outputs sampled 1 unit later.
// Backpressure: stall and imem_ready are randomized in the random scenario.
module tb_pc_sequencer;

`ifdef PC_SEQ_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic clk;
  logic reset;
  int   nChecks;
  int   nPass;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural view only (started flag, PC, ID slot).
  bit          mRun;
  logic [31:0] mPc;
  logic [31:0] mIdPc;
  bit          mIdValid;

  task automatic resetModel();
    mRun = 0; mPc = 32'h0; mIdPc = 32'h0; mIdValid = 0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic modelEdge();
    int          off;
    logic [31:0] tgt;
    logic [31:0] oldPc;
    bit          taken;
    if (reset) begin
      resetModel();
      return;
    end
    if (bus.stall) return;
    taken = bus.leap && mIdValid;
    if (bus.long_offset)
      off = int'(bus.imm) - (bus.imm[25] ? (1 << 26) : 0);
    else
      off = int'(bus.imm[15:0]) - (bus.imm[15] ? 65536 : 0);
    tgt = bus.reg_jump ? bus.busA : (mIdPc + 32'd4 + 32'(off));
    tgt = tgt & 32'hFFFF_FFFC;
    oldPc = mPc;
    if (mRun) begin
      if (taken)               mPc = tgt;
      else if (bus.imem_ready) mPc = mPc + 32'd4;
    end
    mIdValid = mRun && bus.imem_ready && (DS || !taken);
    mIdPc    = oldPc;
    mRun     = 1;
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.stall = 0; bus.leap = 0; bus.reg_jump = 0; bus.long_offset = 0;
    bus.link = 0; bus.busA = '0; bus.imm = '0; bus.imem_ready = 1;
  endtask

  // Clear controls and run two edges so ID surely holds a valid instruction.
  task automatic settle();
    quiet();
    tick();
    tick();
  endtask

  task automatic test_reset();
    quiet();
    bus.link = 1; bus.leap = 1;
    reset = 1;
    resetModel();
    #1;
    nChecks++; if (bus.fetch_pc !== 32'h0) $display("FAIL rst_fetch_pc got %h want 0", bus.fetch_pc); else nPass++;
    nChecks++; if (bus.fetch_valid !== 1'b0) $display("FAIL rst_fetch_valid got %b want 0", bus.fetch_valid); else nPass++;
    nChecks++; if (bus.id_valid !== 1'b0) $display("FAIL rst_id_valid got %b want 0", bus.id_valid); else nPass++;
    nChecks++; if (bus.id_pc !== 32'h0) $display("FAIL rst_id_pc got %h want 0", bus.id_pc); else nPass++;
    nChecks++; if (bus.link_we !== 1'b0) $display("FAIL rst_link_we got %b want 0", bus.link_we); else nPass++;
    tick();
    quiet();
    reset = 0;
    #1;
    nChecks++; if (bus.fetch_valid !== 1'b0) $display("FAIL boot_fetch_valid got %b want 0", bus.fetch_valid); else nPass++;
    tick();
    nChecks++; if (bus.fetch_pc !== 32'h0) $display("FAIL run0_fetch_pc got %h want 0", bus.fetch_pc); else nPass++;
    nChecks++; if (bus.fetch_valid !== 1'b1) $display("FAIL run0_fetch_valid got %b want 1", bus.fetch_valid); else nPass++;
    nChecks++; if (bus.id_valid !== 1'b0) $display("FAIL run0_id_valid got %b want 0", bus.id_valid); else nPass++;
    tick();
    nChecks++; if (bus.fetch_pc !== 32'h4) $display("FAIL run1_fetch_pc got %h want 4", bus.fetch_pc); else nPass++;
    nChecks++; if (bus.id_valid !== 1'b1) $display("FAIL run1_id_valid got %b want 1", bus.id_valid); else nPass++;
    tick();
    nChecks++; if (bus.fetch_pc !== 32'h8) $display("FAIL run2_fetch_pc got %h want 8", bus.fetch_pc); else nPass++;
    nChecks++; if (bus.id_pc !== 32'h4) $display("FAIL run2_id_pc got %h want 4", bus.id_pc); else nPass++;
  endtask

  task automatic test_redirect_short();
    settle();
    bus.leap = 1; bus.reg_jump = 1; bus.busA = 32'h100;
    tick();
    nChecks++; if (bus.fetch_pc !== 32'h100) $display("FAIL jr100_fetch_pc got %h want 100", bus.fetch_pc); else nPass++;
    quiet();
    tick();
    nChecks++; if (bus.id_pc !== 32'h100 || bus.id_valid !== 1'b1) $display("FAIL id100 got %h/%b want 100/1", bus.id_pc, bus.id_valid); else nPass++;
    bus.leap = 1; bus.long_offset = 0; bus.imm = 26'h0010;
    tick();
    nChecks++; if (bus.fetch_pc !== 32'h114) $display("FAIL beqz_fetch_pc got %h want 114", bus.fetch_pc); else nPass++;
    nChecks++; if (bus.id_valid !== DS) $display("FAIL beqz_squash got %b want %b", bus.id_valid, DS); else nPass++;
    nChecks++; if (bus.id_pc !== 32'h104) $display("FAIL beqz_id_pc got %h want 104", bus.id_pc); else nPass++;
    quiet();
  endtask

  task automatic test_wrap_and_regjump();
    settle();
    bus.leap = 1; bus.reg_jump = 1; bus.busA = 32'h0;
    tick();
    quiet();
    tick();
    nChecks++; if (bus.id_pc !== 32'h0 || bus.id_valid !== 1'b1) $display("FAIL id0 got %h/%b want 0/1", bus.id_pc, bus.id_valid); else nPass++;
    bus.leap = 1; bus.long_offset = 1; bus.imm = 26'h3FFFFFC;
    tick();
    nChecks++; if (bus.fetch_pc !== 32'h0) $display("FAIL wrap_fetch_pc got %h want 0", bus.fetch_pc); else nPass++;
    quiet();
    tick();
    bus.leap = 1; bus.reg_jump = 1; bus.busA = 32'h203;
    tick();
    nChecks++; if (bus.fetch_pc !== 32'h200) $display("FAIL jr_align_fetch_pc got %h want 200", bus.fetch_pc); else nPass++;
    quiet();
  endtask

  task automatic test_stall_leap();
    settle();
    bus.leap = 1; bus.reg_jump = 1; bus.busA = 32'h500;
    tick();
    quiet();
    tick();
    bus.stall = 1; bus.leap = 1; bus.link = 1; bus.reg_jump = 1; bus.busA = 32'h600;
    for (int i = 0; i < 3; i++) begin
      #1;
      nChecks++; if (bus.link_we !== 1'b0) $display("FAIL stall_link_we[%0d] got %b want 0", i, bus.link_we); else nPass++;
      nChecks++; if (bus.fetch_pc !== 32'h504) $display("FAIL stall_fetch_pc[%0d] got %h want 504", i, bus.fetch_pc); else nPass++;
      nChecks++; if (bus.id_pc !== 32'h500 || bus.id_valid !== 1'b1) $display("FAIL stall_id[%0d] got %h/%b want 500/1", i, bus.id_pc, bus.id_valid); else nPass++;
      tick();
    end
    bus.stall = 0;
    #1;
    nChecks++; if (bus.link_we !== 1'b1) $display("FAIL unstall_link_we got %b want 1", bus.link_we); else nPass++;
    tick();
    nChecks++; if (bus.fetch_pc !== 32'h600) $display("FAIL unstall_fetch_pc got %h want 600", bus.fetch_pc); else nPass++;
    quiet();
  endtask

  task automatic test_link();
    logic [31:0] expLink;
    expLink = 32'h40 + (DS ? 32'd8 : 32'd4);
    settle();
    bus.leap = 1; bus.reg_jump = 1; bus.busA = 32'h40;
    tick();
    quiet();
    tick();
    bus.link = 1;
    #1;
    nChecks++; if (bus.link_we !== 1'b0) $display("FAIL link_noleap got %b want 0", bus.link_we); else nPass++;
    bus.leap = 1; bus.long_offset = 1; bus.imm = 26'h20;
    #1;
    nChecks++; if (bus.link_we !== 1'b1) $display("FAIL jal_link_we got %b want 1", bus.link_we); else nPass++;
    nChecks++; if (bus.link_value !== expLink) $display("FAIL jal_link_value got %h want %h", bus.link_value, expLink); else nPass++;
    tick();
    nChecks++; if (bus.fetch_pc !== 32'h64) $display("FAIL jal_fetch_pc got %h want 64", bus.fetch_pc); else nPass++;
    quiet();
  endtask

  task automatic test_wait_and_reset();
    settle();
    bus.leap = 1; bus.reg_jump = 1; bus.busA = 32'h800;
    tick();
    quiet();
    bus.imem_ready = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      nChecks++; if (bus.fetch_pc !== 32'h800) $display("FAIL wait_fetch_pc[%0d] got %h want 800", i, bus.fetch_pc); else nPass++;
      nChecks++; if (bus.id_valid !== 1'b0 || bus.fetch_valid !== 1'b1) $display("FAIL wait_valid[%0d] got id %b fv %b want 0/1", i, bus.id_valid, bus.fetch_valid); else nPass++;
    end
    #2;
    reset = 1;
    resetModel();
    #1;
    nChecks++; if (bus.fetch_pc !== 32'h0) $display("FAIL midrst_fetch_pc got %h want 0", bus.fetch_pc); else nPass++;
    nChecks++; if (bus.fetch_valid !== 1'b0) $display("FAIL midrst_fetch_valid got %b want 0", bus.fetch_valid); else nPass++;
    tick();
    reset = 0;
    quiet();
    tick();
    nChecks++; if (bus.fetch_pc !== 32'h0 || bus.fetch_valid !== 1'b1) $display("FAIL postrst got %h/%b want 0/1", bus.fetch_pc, bus.fetch_valid); else nPass++;
  endtask

  task automatic test_random();
    logic [31:0] expLink;
    bit          expLinkWe;
    quiet();
    reset = 1;
    resetModel();
    tick();
    reset = 0;
    for (int n = 0; n < 600; n++) begin
      reset           = ($urandom_range(99) == 0);
      bus.stall       = ($urandom_range(4) == 0);
      bus.leap        = ($urandom_range(9) < 3);
      bus.reg_jump    = ($urandom_range(3) == 0);
      bus.long_offset = $urandom_range(1);
      bus.link        = $urandom_range(1);
      bus.busA        = $urandom;
      bus.imm         = 26'($urandom);
      bus.imem_ready  = ($urandom_range(4) != 0);
      if (reset) resetModel();
      #1;
      expLinkWe = bus.link && bus.leap && mIdValid && !bus.stall;
      expLink   = mIdPc + (DS ? 32'd8 : 32'd4);
      nChecks++; if (bus.fetch_pc !== mPc) $display("FAIL rnd_fetch_pc[%0d] got %h want %h", n, bus.fetch_pc, mPc); else nPass++;
      nChecks++; if (bus.fetch_valid !== mRun) $display("FAIL rnd_fetch_valid[%0d] got %b want %b", n, bus.fetch_valid, mRun); else nPass++;
      nChecks++; if (bus.id_pc !== mIdPc) $display("FAIL rnd_id_pc[%0d] got %h want %h", n, bus.id_pc, mIdPc); else nPass++;
      nChecks++; if (bus.id_valid !== mIdValid) $display("FAIL rnd_id_valid[%0d] got %b want %b", n, bus.id_valid, mIdValid); else nPass++;
      nChecks++; if (bus.link_we !== expLinkWe) $display("FAIL rnd_link_we[%0d] got %b want %b", n, bus.link_we, expLinkWe); else nPass++;
      nChecks++; if (bus.link_value !== expLink) $display("FAIL rnd_link_value[%0d] got %h want %h", n, bus.link_value, expLink); else nPass++;
      tick();
    end
    reset = 0;
    quiet();
  endtask

  initial begin
    nChecks = 0;
    nPass   = 0;
    reset   = 1;
    quiet();
    resetModel();
    test_reset();
    test_redirect_short();
    test_wrap_and_regjump();
    test_stall_leap();
    test_link();
    test_wait_and_reset();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
